// File: rtl/game_pace_controller.sv
// Game sequencer: IDLE/PLAY/PAUSE/OVER FSM, 4-digit BCD score, miss counter and pace tick.
// Optional macro STREAK_BONUS_EN: three consecutive Hits make each further Hit worth 2.
module game_pace_controller #(
    parameter int unsigned BASE_PERIOD = 50000000,
    parameter int unsigned STEP_PERIOD = 5000000,
    parameter int unsigned MAX_MISSES  = 3,
    parameter int unsigned CNT_W       = 26
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       PauseToggle,
    input  logic       Hit,
    input  logic       Miss,
    input  logic [3:0] Difficulty,
    output logic [3:0] ScoreThousands,
    output logic [3:0] ScoreHundreds,
    output logic [3:0] ScoreTens,
    output logic [3:0] ScoreOnes,
    output logic [3:0] CurDifficulty,
    output logic [3:0] MissCount,
    output logic       Tick,
    output logic       Playing,
    output logic       Paused,
    output logic       GameOver
);

    localparam int unsigned PW = CNT_W + 4;

    typedef enum logic [1:0] {StIdle, StPlay, StPause, StOver} stateT;

    stateT            state, nextState;
    logic [15:0]      score, scoreNext;
    logic [3:0]       missCnt, missNext;
    logic [3:0]       curDiff, clampDiff;
    logic [CNT_W-1:0] tickCnt;
    logic [PW-1:0]    periodLast;
    logic             tickQ, startGame, stayPlay, wrap, missLimit;

    // Saturating BCD increment; 9999 is sticky.
    function automatic logic [15:0] bcdInc(input logic [15:0] s);
        logic [15:0] r;
        logic        carry;
        r     = s;
        carry = (s != 16'h9999);
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        if (Difficulty == 4'd0) begin
            clampDiff = 4'd1;
        end else if (Difficulty > 4'd8) begin
            clampDiff = 4'd8;
        end else begin
            clampDiff = Difficulty;
        end
    end

    assign periodLast = PW'(BASE_PERIOD) - PW'(curDiff - 4'd1) * PW'(STEP_PERIOD) - PW'(1);
    assign wrap       = ({{4{1'b0}}, tickCnt} == periodLast);
    assign missNext   = missCnt + 4'd1;
    assign missLimit  = Miss && (missNext == 4'(MAX_MISSES));
    assign startGame  = Start && ((state == StIdle) || (state == StOver));
    // Counter only advances while PLAY persists, so a pause freezes it at the toggle edge.
    assign stayPlay   = (state == StPlay) && (nextState == StPlay);

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= StIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            StIdle:  if (Start) nextState = StPlay;
            StPlay: begin
                if (missLimit) begin
                    nextState = StOver;
                end else if (PauseToggle) begin
                    nextState = StPause;
                end
            end
            StPause: if (PauseToggle) nextState = StPlay;
            StOver:  if (Start) nextState = StPlay;
            default: nextState = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        Playing  = 1'b0;
        Paused   = 1'b0;
        GameOver = 1'b0;
        unique case (state)
            StPlay:  Playing  = 1'b1;
            StPause: Paused   = 1'b1;
            StOver:  GameOver = 1'b1;
            default: ;
        endcase
    end

`ifdef STREAK_BONUS_EN
    logic [1:0] streak;

    // A Hit paired with a Miss never earns the bonus.
    always_comb begin
        if ((streak == 2'd3) && !Miss) begin
            scoreNext = bcdInc(bcdInc(score));
        end else begin
            scoreNext = bcdInc(score);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            streak <= 2'd0;
        end else if (startGame) begin
            streak <= 2'd0;
        end else if (state == StPlay) begin
            if (Miss) begin
                streak <= 2'd0;
            end else if (Hit && (streak != 2'd3)) begin
                streak <= streak + 2'd1;
            end
        end
    end
`else
    always_comb scoreNext = bcdInc(score);
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            score   <= 16'h0000;
            missCnt <= 4'd0;
            tickCnt <= '0;
            curDiff <= 4'd1;
            tickQ   <= 1'b0;
        end else begin
            tickQ <= stayPlay && wrap;
            if (startGame) begin
                score   <= 16'h0000;
                missCnt <= 4'd0;
                tickCnt <= '0;
                curDiff <= clampDiff;
            end else if (state == StPlay) begin
                if (Hit) score <= scoreNext;
                if (Miss) missCnt <= missNext;
                if (stayPlay) begin
                    if (wrap) begin
                        tickCnt <= '0;
                        curDiff <= clampDiff;
                    end else begin
                        tickCnt <= tickCnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign ScoreThousands = score[15:12];
    assign ScoreHundreds  = score[11:8];
    assign ScoreTens      = score[7:4];
    assign ScoreOnes      = score[3:0];
    assign CurDifficulty  = curDiff;
    assign MissCount      = missCnt;
    assign Tick           = tickQ;

endmodule
